// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and word type.
//   ALU_WIDTH : default operand/sum width of the ALU word
//   ALU_SPLIT : default width of the low carry segment in pipe_adder32
//   word_t    : ALU word, shared with the downstream pipeline register
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_SPLIT = 16;

  typedef logic [ALU_WIDTH-1:0] word_t;

endpackage : alu_pkg

// File: rtl/pipe_add_stage.sv
// Generic valid/ready register slice: one valid flop plus a DW-bit data flop.
// The slice loads whenever it is empty or its downstream consumer takes the
// current word, so empty slots (bubbles) are always overwritten.
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   up_valid    : incoming word is valid
//   up_data     : incoming word
//   adv_c       : combinational, slice loads on this edge (upstream ready)
//   down_ready  : downstream consumes the held word this cycle
//   valid, data : registered slice contents
module pipe_add_stage #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          adv_c,
  input  logic          down_ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // Advance when empty or the held word leaves this cycle.
  assign adv_c = !valid || down_ready;

  // Data loads unconditionally on advance; it only matters when valid is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv_c) begin
      valid <= up_valid;
      data  <= up_data;
    end
  end

endmodule : pipe_add_stage

// File: rtl/pipe_adder32.sv
// Two-stage pipelined adder producing the ALU operand word.
// The low SPLIT bits (plus cin) are added in stage 1; the carry out of that
// half (c_mid) is registered and consumed by the high-half add in stage 2.
// Optional feature macro: PIPE_ADD_OVF_EN adds the registered signed-overflow
// output ovf.
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin            : operands and carry in
//   out_valid / out_ready: result handshake
//   sum, cout            : registered (a + b + cin) and carry out
//   ovf                  : registered signed overflow (PIPE_ADD_OVF_EN only)
module pipe_adder32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SPLIT = ALU_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned HW = WIDTH - SPLIT;
  localparam int unsigned LW = SPLIT + 1;
  localparam int unsigned HI_LSB = SPLIT + 1;
`ifdef PIPE_ADD_OVF_EN
  localparam int unsigned S1W = SPLIT + 1 + 2 * HW + 2;
  localparam int unsigned S2W = WIDTH + 2;
`else
  localparam int unsigned S1W = SPLIT + 1 + 2 * HW;
  localparam int unsigned S2W = WIDTH + 1;
`endif

  logic           adv1_c;
  logic           adv2_c;
  logic           v1;
  logic           v2;
  logic [S1W-1:0] s1_d;
  logic [S1W-1:0] s1_q;
  logic [S2W-1:0] s2_d;
  logic [S2W-1:0] s2_q;

  // Stage 1 combinational: low-half add, carry out lands in lo_full[SPLIT].
  logic [LW-1:0]  lo_full;
  assign lo_full = {1'b0, a[SPLIT-1:0]} + {1'b0, b[SPLIT-1:0]} + LW'(cin);

  // Stage 1 payload layout (LSB first): lo_sum, c_mid, b_hi, a_hi[, sb, sa].
`ifdef PIPE_ADD_OVF_EN
  assign s1_d = {a[WIDTH-1], b[WIDTH-1], a[WIDTH-1:SPLIT], b[WIDTH-1:SPLIT], lo_full};
`else
  assign s1_d = {a[WIDTH-1:SPLIT], b[WIDTH-1:SPLIT], lo_full};
`endif

  pipe_add_stage #(.DW(S1W)) u_stage1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (in_valid),
    .up_data    (s1_d),
    .adv_c      (adv1_c),
    .down_ready (adv2_c),
    .valid      (v1),
    .data       (s1_q)
  );

  assign in_ready = adv1_c;

  // Unpack stage 1 registers.
  logic [SPLIT-1:0] lo_sum;
  logic             c_mid;
  logic [HW-1:0]    a_hi;
  logic [HW-1:0]    b_hi;
  assign lo_sum = s1_q[SPLIT-1:0];
  assign c_mid  = s1_q[SPLIT];
  assign b_hi   = s1_q[HI_LSB +: HW];
  assign a_hi   = s1_q[HI_LSB + HW +: HW];

  // Stage 2 combinational: high-half add; c_mid is the only cross-split carry.
  logic [HW:0] hi_full;
  assign hi_full = {1'b0, a_hi} + {1'b0, b_hi} + (HW + 1)'(c_mid);

`ifdef PIPE_ADD_OVF_EN
  // Overflow: like-signed operands producing a result of the other sign.
  logic sa;
  logic sb;
  logic ovf_c;
  assign sa    = s1_q[HI_LSB + 2 * HW + 1];
  assign sb    = s1_q[HI_LSB + 2 * HW];
  assign ovf_c = (sa == sb) && (hi_full[HW-1] != sa);
  assign s2_d  = {ovf_c, hi_full, lo_sum};
`else
  assign s2_d  = {hi_full, lo_sum};
`endif

  pipe_add_stage #(.DW(S2W)) u_stage2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (v1),
    .up_data    (s2_d),
    .adv_c      (adv2_c),
    .down_ready (out_ready),
    .valid      (v2),
    .data       (s2_q)
  );

  // Outputs come straight from stage 2 flops.
  assign out_valid = v2;
  assign sum       = s2_q[WIDTH-1:0];
  assign cout      = s2_q[WIDTH];
`ifdef PIPE_ADD_OVF_EN
  assign ovf       = s2_q[WIDTH+1];
`endif

endmodule : pipe_adder32

// File: tb/tb_pipe_adder32.sv
// Scoreboard bench for pipe_adder32: the driver pushes hand-computed or
// model-computed results on each accepted operand set; a monitor pops and
// compares whenever a result is handed off downstream.
module tb_pipe_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef PIPE_ADD_OVF_EN
  logic        ovf;
`endif

  pipe_adder32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int unsigned acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        expq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned stall_lo = 1;
  int unsigned stall_hi = 0;
  bit          bp_chk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [31:0] held = '0;
    bit          stalled = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (out_valid && !out_ready) begin
          if (stalled) check("stall_hold_sum", 64'(sum), 64'(held));
          stalled = 1;
          held    = sum;
        end else begin
          stalled = 0;
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_valid: got out_valid=1 sum=0x%0h expected no result (cycle %0d)", sum, cyc);
          end else begin
            e = expq.pop_front();
            check("sum", 64'(sum), 64'(e.s));
            check("cout", 64'(cout), 64'(e.c));
`ifdef PIPE_ADD_OVF_EN
            check("ovf", 64'(ovf), 64'(e.o));
`endif
            if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(2));
          end
        end
      end
    end
  endtask

  // Present one operand set, retrying until accepted (bounded).
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                      input logic [31:0] es, input logic ec, input logic eo, input bit chk);
    bit   done = 0;
    exp_t e;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb_;
      cin       = tc;
      #1;
      if (bp_chk && !out_ready) check("in_ready_blocked", 64'(in_ready), 64'(0));
      if (in_ready) begin
        e.s = es; e.c = ec; e.o = eo; e.acc_cyc = cyc; e.chk_lat = chk;
        expq.push_back(e);
        done = 1;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  endtask

  task automatic drain();
    bit empty = 0;
    for (int k = 0; k < 100 && !empty; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      empty = (expq.size() == 0) && !out_valid;
    end
    check("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  // Model-based result for the streaming test.
  task automatic send_model(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input bit chk);
    logic [32:0] full;
    logic        eo;
    full = 33'(ta) + 33'(tb_) + 33'(tc);
    eo   = (ta[31] == tb_[31]) && (full[31] != ta[31]);
    send(ta, tb_, tc, full[31:0], full[32], eo, chk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors, hand-computed: a, b, cin -> sum, cout, ovf
    send(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1);
    idle(3);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1);
    send(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 1);
    send(32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0, 1'b0, 1);
    drain();

    // Backpressure: stream i+1, out_ready low for cycles 3..6 of the stream
    stall_lo = cyc + 1 + 3;
    stall_hi = cyc + 1 + 6;
    bp_chk   = 1;
    for (int i = 0; i < 10; i++)
      send(32'(i), 32'h00000001, 1'b0, 32'(i + 1), 1'b0, 1'b0, 0);
    bp_chk   = 0;
    stall_lo = 1;
    stall_hi = 0;
    drain();

    // Full throughput
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ta;
      logic [31:0] tb_;
      ta  = 32'h9E3779B9 * 32'(i) + 32'h00000013;
      tb_ = ta ^ (32'hA5A50000 + 32'(i));
      send_model(ta, tb_, 1'(i), 1);
    end
    drain();

    // Bubbles: valid, gap, valid, gap, valid
    send(32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0, 1'b0, 1);
    idle(1);
    send(32'h00000100, 32'h00000200, 1'b1, 32'h00000301, 1'b0, 1'b0, 1);
    idle(1);
    send(32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1);
    drain();

    // Reset with both stages full and the output stalled
    stall_lo = 0;
    stall_hi = 32'hFFFFFFFF;
    send(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 0);
    send(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    expq.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'(1));
    stall_lo = 1;
    stall_hi = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("postrst_no_stale_valid", 64'(out_valid), 64'(0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipe_adder32
